// File: rtl/ultrascan_report_collector_pkg.sv
// Shared definitions for the UltraScan report collector: default widths,
// the occupancy-width helper and the default-width record layout.
package ultrascan_report_pkg;

  localparam int NUM_REPORTS_DEF    = 1;
  localparam int OFFSET_WIDTH_DEF   = 32;
  localparam int FIFO_DEPTH_DEF     = 16;
  localparam int DROP_CNT_WIDTH_DEF = 16;

  // Occupancy counters must represent 0..depth inclusive, hence one extra bit.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int COUNT_W = count_w(FIFO_DEPTH_DEF);

  // One buffered report event: the symbol offset that caused it and the
  // report STE bits seen for that symbol.
  typedef struct packed {
    logic [OFFSET_WIDTH_DEF-1:0] offset;
    logic [NUM_REPORTS_DEF-1:0]  vector;
  } report_rec_t;

endpackage

// File: rtl/ultrascan_report_collector_if.sv
// Report record stream from the collector to the host/kernel writer.
// The collector drives the master side; the consumer uses the slave side.
interface ultrascan_report_collector_if
  import ultrascan_report_pkg::*;
#(
  parameter int NUM_REPORTS  = NUM_REPORTS_DEF,
  parameter int OFFSET_WIDTH = OFFSET_WIDTH_DEF
);

  logic                    rpt_valid;
  logic                    rpt_ready;
  logic [OFFSET_WIDTH-1:0] rpt_offset;
  logic [NUM_REPORTS-1:0]  rpt_vector;

  modport master (
    output rpt_valid,
    output rpt_offset,
    output rpt_vector,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid,
    input  rpt_offset,
    input  rpt_vector,
    output rpt_ready
  );

endinterface

// File: rtl/ultrascan_report_collector_fifo.sv
// Single-clock show-ahead FIFO of report records. The head entry is visible
// combinationally on rdata_o whenever empty_o is low.
module report_fifo
  import ultrascan_report_pkg::*;
#(
  parameter type rec_t = report_rec_t,
  parameter int  DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push_i,
  input  rec_t                      wdata_i,
  input  logic                      pop_i,
  output rec_t                      rdata_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [count_w(DEPTH)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = count_w(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  rec_t             mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop is only real when data is present; a push into a full FIFO is only
  // legal when the same cycle frees the head slot.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next occupancy: push and pop together leave it unchanged.
  always_comb begin
    // NOTE: default assignment first so every path assigns count_d; otherwise a latch is inferred.
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so all registers update from pre-edge values.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Record storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; entries are only read once count_q says they were written.
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ultrascan_report_collector.sv
// Downstream end of the automaton symbol->report path. Tracks the symbol
// offset, captures {offset, report vector} records one cycle after each
// reporting symbol, buffers them and drains them over a valid/ready stream.
// Records arriving while the buffer is full and not draining are dropped
// and counted; the automaton is never stalled.
module ultrascan_report_collector
  import ultrascan_report_pkg::*;
#(
  parameter int NUM_REPORTS    = NUM_REPORTS_DEF,
  parameter int OFFSET_WIDTH   = OFFSET_WIDTH_DEF,
  parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF,
  parameter int DROP_CNT_WIDTH = DROP_CNT_WIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           run,
  input  logic [NUM_REPORTS-1:0]         report_in,
  ultrascan_report_collector_if.master   rpt,
  output logic [count_w(FIFO_DEPTH)-1:0] fifo_count,
  output logic                           overflow,
  output logic [DROP_CNT_WIDTH-1:0]      drop_cnt
);

  // Record layout at this instance's widths (same shape as report_rec_t).
  typedef struct packed {
    logic [OFFSET_WIDTH-1:0] offset;
    logic [NUM_REPORTS-1:0]  vector;
  } coll_rec_t;

  logic [OFFSET_WIDTH-1:0]   symbol_cnt_q, symbol_cnt_d;
  logic                      run_q;
  logic                      overflow_q, overflow_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  logic      capture, push, pop, drop;
  logic      fifo_full, fifo_empty;
  coll_rec_t push_rec, head_rec;

  // STE outputs lag their symbol by one cycle, so a report is only meaningful
  // when the previous cycle actually presented a symbol. This also ignores
  // active_state held high while the stream is stalled.
  assign capture = run_q && (|report_in);

  // symbol_cnt_q already counts the reporting symbol, so its offset is one less.
  assign push_rec = '{offset: symbol_cnt_q - 1'b1, vector: report_in};

  assign pop  = !fifo_empty && rpt.rpt_ready;
  assign push = capture && (!fifo_full || pop);
  assign drop = capture && fifo_full && !pop;

  report_fifo #(
    .rec_t (coll_rec_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (push_rec),
    .pop_i   (pop),
    .rdata_o (head_rec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Stream outputs; fields read as zero while nothing is buffered so stale
  // storage never shows on the bus.
  assign rpt.rpt_valid  = !fifo_empty;
  assign rpt.rpt_offset = fifo_empty ? '0 : head_rec.offset;
  assign rpt.rpt_vector = fifo_empty ? '0 : head_rec.vector;

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

  // Next-state for the symbol counter (free-running wrap) and drop tracking
  // (sticky flag, saturating count).
  always_comb begin
    symbol_cnt_d = symbol_cnt_q;
    overflow_d   = overflow_q;
    drop_cnt_d   = drop_cnt_q;
    if (run) symbol_cnt_d = symbol_cnt_q + 1'b1;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  // Collector state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      symbol_cnt_q <= '0;
      run_q        <= 1'b0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      symbol_cnt_q <= symbol_cnt_d;
      run_q        <= run;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_ultrascan_report_collector.sv
// Self-checking bench for ultrascan_report_collector. Two instances share the
// stimulus: a default-width one (1 report bit, 32-bit offsets, 16-bit drop
// counter) and a narrow one (3 report bits, 4-bit offsets, 3-bit drop counter)
// so offset wrap and drop-count saturation are reachable. A queue-based
// reference model predicts every output each cycle.
module tb_ultrascan_report_collector;
  import ultrascan_report_pkg::*;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset, run, ready;
  logic [2:0] rep;

  logic [4:0]  cnt_a, cnt_b;
  logic        ovf_a, ovf_b;
  logic [15:0] drop_a;
  logic [2:0]  drop_b;

  always #5 clk = ~clk;

  ultrascan_report_collector_if #(.NUM_REPORTS(1), .OFFSET_WIDTH(32)) if_a ();
  ultrascan_report_collector_if #(.NUM_REPORTS(3), .OFFSET_WIDTH(4))  if_b ();

  assign if_a.rpt_ready = ready;
  assign if_b.rpt_ready = ready;

  ultrascan_report_collector #(
    .NUM_REPORTS(1), .OFFSET_WIDTH(32), .FIFO_DEPTH(DEPTH), .DROP_CNT_WIDTH(16)
  ) u_a (
    .clk(clk), .reset(reset), .run(run), .report_in(rep[0:0]), .rpt(if_a),
    .fifo_count(cnt_a), .overflow(ovf_a), .drop_cnt(drop_a)
  );

  ultrascan_report_collector #(
    .NUM_REPORTS(3), .OFFSET_WIDTH(4), .FIFO_DEPTH(DEPTH), .DROP_CNT_WIDTH(3)
  ) u_b (
    .clk(clk), .reset(reset), .run(run), .report_in(rep), .rpt(if_b),
    .fifo_count(cnt_b), .overflow(ovf_b), .drop_cnt(drop_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned off;
    int unsigned vec;
  } exp_rec_t;

  exp_rec_t    mq_a[$], mq_b[$];
  int unsigned m_sym[2];
  bit          m_prev_run[2];
  bit          m_ovf[2];
  int unsigned m_drops[2];

  int unsigned plog_a[$], plog_b[$];   // offsets accepted by the consumer

  function automatic int unsigned off_mask(input int k);
    return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
  endfunction

  function automatic int unsigned drop_max(input int k);
    return (k == 0) ? 65535 : 7;
  endfunction

  function automatic int unsigned rep_mask(input int k);
    return (k == 0) ? 1 : 7;
  endfunction

  function automatic int m_size(input int k);
    return (k == 0) ? mq_a.size() : mq_b.size();
  endfunction

  function automatic int unsigned head_off(input int k);
    return (k == 0) ? mq_a[0].off : mq_b[0].off;
  endfunction

  function automatic int unsigned head_vec(input int k);
    return (k == 0) ? mq_a[0].vec : mq_b[0].vec;
  endfunction

  function automatic int unsigned log_at(input int k, input int i);
    if (k == 0) return (i < plog_a.size()) ? plog_a[i] : 32'hDEAD_BEEF;
    return (i < plog_b.size()) ? plog_b[i] : 32'hDEAD_BEEF;
  endfunction

  // Effect of one clock edge on instance k, computed from the behavioural rules.
  task automatic model_step(input int k, input bit r, input bit rn,
                            input logic [2:0] rp, input bit rdy);
    int unsigned v;
    bit          pop, cap;
    int          sz;
    exp_rec_t    rec;
    if (r) begin
      if (k == 0) mq_a.delete(); else mq_b.delete();
      m_sym[k] = 0; m_prev_run[k] = 0; m_ovf[k] = 0; m_drops[k] = 0;
      return;
    end
    v   = 32'(rp) & rep_mask(k);
    sz  = m_size(k);
    pop = (sz > 0) && rdy;
    cap = m_prev_run[k] && (v != 0);
    if (pop) begin
      if (k == 0) mq_a.delete(0); else mq_b.delete(0);
    end
    if (cap) begin
      if (sz < DEPTH || pop) begin
        rec.off = (m_sym[k] - 1) & off_mask(k);
        rec.vec = v;
        if (k == 0) mq_a.push_back(rec); else mq_b.push_back(rec);
      end else begin
        m_ovf[k] = 1'b1;
        if (m_drops[k] < drop_max(k)) m_drops[k]++;
      end
    end
    if (rn) m_sym[k]++;
    m_prev_run[k] = rn;
  endtask

  task automatic compare_all();
    check("a_valid", 32'(if_a.rpt_valid), 32'(m_size(0) != 0));
    check("a_count", 32'(cnt_a), m_size(0));
    check("a_ovf",   32'(ovf_a), 32'(m_ovf[0]));
    check("a_drop",  32'(drop_a), m_drops[0]);
    if (m_size(0) != 0) begin
      check("a_off", if_a.rpt_offset, head_off(0));
      check("a_vec", 32'(if_a.rpt_vector), head_vec(0));
    end
    check("b_valid", 32'(if_b.rpt_valid), 32'(m_size(1) != 0));
    check("b_count", 32'(cnt_b), m_size(1));
    check("b_ovf",   32'(ovf_b), 32'(m_ovf[1]));
    check("b_drop",  32'(drop_b), m_drops[1]);
    if (m_size(1) != 0) begin
      check("b_off", 32'(if_b.rpt_offset), head_off(1));
      check("b_vec", 32'(if_b.rpt_vector), head_vec(1));
    end
  endtask

  // Drive one cycle's inputs (just after a falling edge), advance the model,
  // then compare every output half a period after the rising edge.
  task automatic cycle(input bit r, input bit rn, input logic [2:0] rp, input bit rdy);
    reset = r; run = rn; rep = rp; ready = rdy;
    if (!r && rdy) begin
      if (if_a.rpt_valid) plog_a.push_back(if_a.rpt_offset);
      if (if_b.rpt_valid) plog_b.push_back(32'(if_b.rpt_offset));
    end
    model_step(0, r, rn, rp, rdy);
    model_step(1, r, rn, rp, rdy);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 3'b000, 1'b0);
    plog_a.delete();
    plog_b.delete();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'b000, rdy);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; rep = '0; ready = 1'b0;
    @(negedge clk);

    // Reset values
    do_reset();
    do_reset();
    check("rst_valid_a", 32'(if_a.rpt_valid), 0);
    check("rst_count_a", 32'(cnt_a), 0);
    check("rst_ovf_a",   32'(ovf_a), 0);
    check("rst_drop_a",  32'(drop_a), 0);
    check("rst_off_a",   if_a.rpt_offset, 0);
    check("rst_vec_a",   32'(if_a.rpt_vector), 0);
    check("rst_off_b",   32'(if_b.rpt_offset), 0);
    check("rst_vec_b",   32'(if_b.rpt_vector), 0);

    // Single report for symbol 3, consumer always ready
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, (i == 4) ? 3'b001 : 3'b000, 1'b1);
    check("single_valid", 32'(if_a.rpt_valid), 1);
    check("single_off_a", if_a.rpt_offset, 3);
    check("single_vec_a", 32'(if_a.rpt_vector), 1);
    check("single_off_b", 32'(if_b.rpt_offset), 3);
    cycle(1'b0, 1'b0, 3'b000, 1'b1);
    check("single_valid_1cyc", 32'(if_a.rpt_valid), 0);
    check("single_drop", 32'(drop_a), 0);
    check("single_nrec", plog_a.size(), 1);
    check("single_log_off", log_at(0, 0), 3);

    // Report held high across a stall yields exactly one record
    do_reset();
    cycle(1'b0, 1'b1, 3'b000, 1'b0);
    cycle(1'b0, 1'b1, 3'b000, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 3'b101, 1'b0);
    check("stall_count_a", 32'(cnt_a), 1);
    check("stall_count_b", 32'(cnt_b), 1);
    check("stall_off_a",   if_a.rpt_offset, 1);
    check("stall_vec_b",   32'(if_b.rpt_vector), 5);
    idle(2, 1'b1);
    check("stall_nrec", plog_a.size(), 1);

    // Fill, overflow, drop saturation, full push+pop, ordered drain
    do_reset();
    for (int i = 0; i < 21; i++) cycle(1'b0, 1'b1, 3'b111, 1'b0);
    check("fill_count_a", 32'(cnt_a), 16);
    check("fill_ovf_a",   32'(ovf_a), 1);
    check("fill_drop_a",  32'(drop_a), 4);
    check("fill_drop_b",  32'(drop_b), 4);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 3'b111, 1'b0);
    check("more_drop_a", 32'(drop_a), 14);
    check("sat_drop_b",  32'(drop_b), 7);
    cycle(1'b0, 1'b0, 3'b111, 1'b1);
    check("fullpp_count", 32'(cnt_a), 16);
    check("fullpp_drop",  32'(drop_a), 14);
    idle(18, 1'b1);
    check("drain_nrec", plog_a.size(), 17);
    for (int i = 0; i < 17; i++) begin
      check("drain_off_a", log_at(0, i), (i < 16) ? i : 30);
      check("drain_off_b", log_at(1, i), (i < 16) ? i : (30 & 15));
    end

    // Random back-pressure, reports on every 3rd symbol
    do_reset();
    for (int t = 0; t <= 100; t++)
      cycle(1'b0, t < 100, ((t >= 1) && ((t - 1) % 3 == 0)) ? 3'b011 : 3'b000,
            $urandom_range(0, 3) != 0);
    idle(40, 1'b1);
    check("bp_nrec_a", plog_a.size(), 34);
    check("bp_nrec_b", plog_b.size(), 34);
    check("bp_drop",   32'(drop_a), 0);
    for (int i = 0; i < 34; i++) begin
      check("bp_off_a", log_at(0, i), 3 * i);
      check("bp_off_b", log_at(1, i), (3 * i) & 15);
    end

    // Offset wrap on the narrow instance
    do_reset();
    for (int t = 0; t <= 18; t++) cycle(1'b0, t < 18, 3'b001, 1'b1);
    idle(2, 1'b1);
    check("wrap_nrec", plog_b.size(), 18);
    for (int i = 0; i < 18; i++) begin
      check("wrap_off_b", log_at(1, i), i % 16);
      check("wrap_off_a", log_at(0, i), i);
    end

    // Reset while full, overflowed and being drained
    for (int i = 0; i < 21; i++) cycle(1'b0, 1'b1, 3'b001, 1'b0);
    check("pre_rst_ovf", 32'(ovf_a), 1);
    cycle(1'b1, 1'b0, 3'b000, 1'b1);
    check("midrst_valid", 32'(if_a.rpt_valid), 0);
    check("midrst_count", 32'(cnt_a), 0);
    check("midrst_ovf",   32'(ovf_a), 0);
    check("midrst_drop",  32'(drop_b), 0);
    cycle(1'b0, 1'b1, 3'b001, 1'b0);
    cycle(1'b0, 1'b1, 3'b001, 1'b0);
    check("postrst_off_a", if_a.rpt_offset, 0);
    check("postrst_off_b", 32'(if_b.rpt_offset), 0);

    // Random soak: slow consumer then fast consumer, occasional resets
    do_reset();
    for (int i = 0; i < 600; i++) begin
      automatic bit         r  = ($urandom_range(0, 99) == 0);
      automatic bit         rn = ($urandom_range(0, 9) < 7);
      automatic logic [2:0] rp = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
      automatic bit         rd = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle(r, rn, rp, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
